// File: rtl/vending_pkg.sv
// Shared constants and types for the vending machine datapath and its coin front end.
package vending_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  localparam int unsigned COIN1_VALUE = 1;
  localparam int unsigned COIN2_VALUE = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT1,
    ST_CREDIT2,
    ST_DISPENSE
  } vend_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_COIN1,
    GRANT_COIN2
  } grant_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin-slot channel: 2-flop synchroniser, persistence-count debouncer and
// a pulse on the edge where the debounced level goes 0->1.
module coin_debounce
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_flip;

  // Flip happens on the DEBOUNCE_CYCLES-th consecutive edge with s2 != stable.
  assign w_flip = (r_s2 != r_stable) && (r_cnt == CNT_LAST);
  assign o_rise = w_flip & r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: two debounced channels, one-deep pending buffer per channel,
// fixed-priority single-pulse arbiter with inhibit and dropped-coin reporting.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_coin1,
  input  logic raw_coin2,
  input  logic inhibit,
  output logic coin1,
  output logic coin2,
  output logic coin_pending,
  output logic overflow
);

  logic   w_rise1;
  logic   w_rise2;
  logic   r_pend1;
  logic   r_pend2;
  logic   r_coin1;
  logic   r_coin2;
  logic   r_overflow;
  grant_t w_grant;
  logic   w_clr1;
  logic   w_clr2;
  logic   w_pend1_nxt;
  logic   w_pend2_nxt;
  logic   w_drop;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_raw   (raw_coin1),
    .o_rise  (w_rise1)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_raw   (raw_coin2),
    .o_rise  (w_rise2)
  );

  always_comb begin
    w_grant = GRANT_NONE;
    if (!inhibit) begin
      if (r_pend1)      w_grant = GRANT_COIN1;
      else if (r_pend2) w_grant = GRANT_COIN2;
    end
  end

  assign w_clr1 = (w_grant == GRANT_COIN1);
  assign w_clr2 = (w_grant == GRANT_COIN2);

  // A new event wins over a same-edge clear, so the fresh coin stays buffered.
  assign w_pend1_nxt = w_rise1 | (r_pend1 & ~w_clr1);
  assign w_pend2_nxt = w_rise2 | (r_pend2 & ~w_clr2);
  assign w_drop      = (w_rise1 & r_pend1 & ~w_clr1) | (w_rise2 & r_pend2 & ~w_clr2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend1    <= 1'b0;
      r_pend2    <= 1'b0;
      r_coin1    <= 1'b0;
      r_coin2    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pend1    <= w_pend1_nxt;
      r_pend2    <= w_pend2_nxt;
      r_coin1    <= w_clr1;
      r_coin2    <= w_clr2;
      r_overflow <= w_drop;
    end
  end

  assign coin1        = r_coin1;
  assign coin2        = r_coin2;
  assign overflow     = r_overflow;
  assign coin_pending = r_pend1 | r_pend2;

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: per-edge vector table, hand-coded reset sequence,
// and randomized bouncy inputs checked against a window-based reference model.
module tb_coin_acceptor;

  localparam int unsigned D = 4;
  localparam int unsigned NVEC = 7;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_coin1 = 1'b0;
  logic raw_coin2 = 1'b0;
  logic inhibit = 1'b0;
  logic coin1, coin2, coin_pending, overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  coin_acceptor #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_coin1    (raw_coin1),
    .raw_coin2    (raw_coin2),
    .inhibit      (inhibit),
    .coin1        (coin1),
    .coin2        (coin2),
    .coin_pending (coin_pending),
    .overflow     (overflow)
  );

  // Bit i of each mask: input driven before edge i / output expected after edge i.
  typedef struct {
    string       name;
    logic [31:0] raw1;
    logic [31:0] raw2;
    logic [31:0] inh;
    logic [31:0] exp_c1;
    logic [31:0] exp_c2;
    logic [31:0] exp_ovf;
    logic [31:0] exp_pend;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {coin1, coin2, overflow, coin_pending};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: c1/c2/ovf/pend got %b, expected %b", name, got, exp);
    end
  endtask

  // Leaves reset asserted at a falling edge; caller releases it.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    raw_coin1 = 1'b0;
    raw_coin2 = 1'b0;
    inhibit = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 4'b0000);
  endtask

  task automatic run_vec(input vec_t v);
    do_reset();
    reset = 1'b1;
    raw_coin1 = v.raw1[0];
    raw_coin2 = v.raw2[0];
    inhibit   = v.inh[0];
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s@%0d", v.name, i),
            {v.exp_c1[i], v.exp_c2[i], v.exp_ovf[i], v.exp_pend[i]});
      @(negedge clk);
      if (i < 31) begin
        raw_coin1 = v.raw1[i+1];
        raw_coin2 = v.raw2[i+1];
        inhibit   = v.inh[i+1];
      end
    end
  endtask

  // Reference model: level flips once the last D synchronised samples all
  // disagree with it; synchronised sample before edge n is raw from edge n-2.
  bit h1[$];
  bit h2[$];
  bit m_stab1, m_stab2, m_pend1, m_pend2;

  function automatic bit window_all(input bit q[$], input bit val);
    int idx;
    bit b;
    for (int j = 2; j <= int'(D) + 1; j++) begin
      idx = q.size() - 1 - j;
      b = (idx >= 0) ? q[idx] : 1'b0;
      if (b != val) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    h1.delete();
    h2.delete();
    m_stab1 = 0; m_stab2 = 0; m_pend1 = 0; m_pend2 = 0;
  endtask

  task automatic model_edge(output logic [3:0] exp);
    bit r1, r2, g1, g2, ovf;
    if (!reset) begin
      model_clear();
      exp = 4'b0000;
      return;
    end
    h1.push_back(raw_coin1);
    h2.push_back(raw_coin2);
    r1 = 0; r2 = 0;
    if (window_all(h1, !m_stab1)) begin m_stab1 = !m_stab1; r1 = m_stab1; end
    if (window_all(h2, !m_stab2)) begin m_stab2 = !m_stab2; r2 = m_stab2; end
    g1  = !inhibit && m_pend1;
    g2  = !inhibit && !m_pend1 && m_pend2;
    ovf = (r1 && m_pend1 && !g1) || (r2 && m_pend2 && !g2);
    m_pend1 = r1 || (m_pend1 && !g1);
    m_pend2 = r2 || (m_pend2 && !g2);
    exp = {g1, g2, ovf, m_pend1 | m_pend2};
    while (h1.size() > int'(D) + 2) void'(h1.pop_front());
    while (h2.size() > int'(D) + 2) void'(h2.pop_front());
  endtask

  initial begin
    logic [3:0] exp;
    int run1, run2, runi, rst_cnt;

    vecs[0] = '{"clean_c1",  32'h3FF,   32'h0,   32'h0,        32'h40,      32'h0,     32'h0,     32'h20};
    vecs[1] = '{"bounce_c2", 32'h0,     32'hFF7, 32'h0,        32'h0,       32'h400,   32'h0,     32'h200};
    vecs[2] = '{"glitch_c2", 32'h0,     32'h7,   32'h0,        32'h0,       32'h0,     32'h0,     32'h0};
    vecs[3] = '{"simult",    32'h3FF,   32'h3FF, 32'h0,        32'h40,      32'h80,    32'h0,     32'h60};
    vecs[4] = '{"inhibit",   32'h3FF,   32'h0,   32'h1FFFFF,   32'h200000,  32'h0,     32'h0,     32'h1FFFE0};
    vecs[5] = '{"overflow",  32'h3F03F, 32'h0,   32'h1FFFFFF,  32'h2000000, 32'h0,     32'h20000, 32'h1FFFFE0};
    vecs[6] = '{"set_clr",   32'h0,     32'h3F03F, 32'h1FFFF,  32'h0,       32'h60000, 32'h0,     32'h3FFE0};

    for (int v = 0; v < int'(NVEC); v++) run_vec(vecs[v]);

    // Reset during a coin1 debounce: no stale pulse, fresh D+2 latency after release.
    do_reset();
    reset = 1'b1;
    raw_coin1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("pre_rst@%0d", i), 4'b0000);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("in_rst_async", 4'b0000);
    @(posedge clk);
    #1;
    check("in_rst_edge", 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst@%0d", i), {i == 6, 1'b0, 1'b0, i == 5});
    end

    // Randomized bouncy inputs with inhibit runs and occasional resets.
    do_reset();
    model_clear();
    run1 = 0; run2 = 0; runi = 0; rst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_cnt > 0) begin
        reset = 1'b0;
        rst_cnt--;
      end else begin
        reset = 1'b1;
        if ($urandom_range(0, 299) == 0) rst_cnt = $urandom_range(1, 2);
      end
      if (run1 == 0) begin raw_coin1 = $urandom_range(0, 1) == 1; run1 = $urandom_range(1, 10); end
      if (run2 == 0) begin raw_coin2 = $urandom_range(0, 1) == 1; run2 = $urandom_range(1, 10); end
      if (runi == 0) begin inhibit = $urandom_range(0, 9) < 3; runi = $urandom_range(1, 15); end
      run1--; run2--; runi--;
      @(posedge clk);
      model_edge(exp);
      #1;
      check($sformatf("rand@%0d", c), exp);
      if (coin1 && coin2) begin
        n_vec++;
        n_err++;
        $display("FAIL rand_exclusive@%0d: coin1=%b coin2=%b, required not both 1", c, coin1, coin2);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
